// File: rtl/bus_frame_decoder_pkg.sv
// ---------------------------------------------------------------------------
// bus_frame_decoder_pkg
// Shared control-bus definitions for the frame decoder slice:
//   - target ids (mem / SHA / AES / reserved)
//   - header byte field positions
//   - 2-bit FSM state encodings
// No ports (package).
// ---------------------------------------------------------------------------
package bus_frame_decoder_pkg;

    localparam int unsigned NUM_TARGETS  = 3;
    localparam int unsigned DEST_W       = 2;

    // Header byte layout: [7:6] dest, [5:4] opcode, [3:0] ignored
    localparam int unsigned HDR_DEST_LSB = 6;
    localparam int unsigned HDR_OPC_LSB  = 4;

    typedef enum logic [1:0] {
        DEST_MEM  = 2'd0,
        DEST_SHA  = 2'd1,
        DEST_AES  = 2'd2,
        DEST_RSVD = 2'd3
    } dest_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/bus_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// bus_frame_decoder_if
// Groups the byte-bus, command and completion/ack signals of the frame decoder.
//   slave  : decoder side (consumes bytes/ready/done, produces command/ack/err)
//   master : control-block / target side (the opposite directions)
// Signals:
//   bus_data_in[7:0], bus_valid_in, bus_ready_out   byte stream handshake
//   cmd_valid, cmd_ready, cmd_dest[1:0],
//   cmd_opcode[OPCODEW-1:0], cmd_addr[ADDRW-1:0]    issued command
//   done_in[2:0], ack_out[2:0], err_out             completion / ack / error
// ---------------------------------------------------------------------------
interface bus_frame_decoder_if #(
    parameter int ADDRW   = 24,
    parameter int OPCODEW = 2
) ();

    logic [7:0]         bus_data_in;
    logic               bus_valid_in;
    logic               bus_ready_out;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_dest;
    logic [OPCODEW-1:0] cmd_opcode;
    logic [ADDRW-1:0]   cmd_addr;
    logic [2:0]         done_in;
    logic [2:0]         ack_out;
    logic               err_out;

    modport slave (
        input  bus_data_in, bus_valid_in, cmd_ready, done_in,
        output bus_ready_out, cmd_valid, cmd_dest, cmd_opcode, cmd_addr,
               ack_out, err_out
    );

    modport master (
        output bus_data_in, bus_valid_in, cmd_ready, done_in,
        input  bus_ready_out, cmd_valid, cmd_dest, cmd_opcode, cmd_addr,
               ack_out, err_out
    );

endinterface

// File: rtl/bus_frame_decoder_tracker.sv
// ---------------------------------------------------------------------------
// outstanding_tracker
// Holds one outstanding bit per target, turns completion strobes into
// registered one-cycle acknowledge pulses, and flags completions that arrive
// for a target with nothing outstanding.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   set_vec[2:0]     command accepted for target i this cycle
//   done_in[2:0]     completion strobe per target
//   outstanding[2:0] registered outstanding bits
//   ack_out[2:0]     registered acknowledge pulse per target
//   spur_evt         combinational: some done_in bit hit an idle target
// ---------------------------------------------------------------------------
module outstanding_tracker
    import bus_frame_decoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_TARGETS-1:0] set_vec,
    input  logic [NUM_TARGETS-1:0] done_in,
    output logic [NUM_TARGETS-1:0] outstanding,
    output logic [NUM_TARGETS-1:0] ack_out,
    output logic                   spur_evt
);

    logic [NUM_TARGETS-1:0] out_q;
    logic [NUM_TARGETS-1:0] ack_q;

    // A handshake only happens for a free target, so set and clear never
    // collide on a legitimately outstanding bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ack_q <= '0;
        end else begin
            out_q <= (out_q & ~done_in) | set_vec;
            ack_q <= done_in & out_q;
        end
    end

    assign spur_evt    = |(done_in & ~out_q);
    assign outstanding = out_q;
    assign ack_out     = ack_q;

endmodule

// File: rtl/bus_frame_decoder.sv
// ---------------------------------------------------------------------------
// bus_frame_decoder
// Reassembles byte-serial frames (header + ADDRW/8 address bytes, LSB first)
// into one command per frame and issues it to the addressed target, with at
// most one outstanding command per target.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          bus_frame_decoder_if.slave: byte stream in, command out,
//                done_in in, ack_out / err_out out
// Parameters:
//   ADDRW   address width, multiple of 8
//   OPCODEW opcode width taken from header bits [4 +: OPCODEW] (<= 2)
// ---------------------------------------------------------------------------
module bus_frame_decoder
    import bus_frame_decoder_pkg::*;
#(
    parameter int ADDRW   = 24,
    parameter int OPCODEW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_frame_decoder_if.slave bus
);

    localparam int NBYTES = ADDRW / 8;
    localparam int CNTW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBYTES - 1);

    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q;
    logic [1:0]         dest_q;
    logic [OPCODEW-1:0] opc_q;
    logic [ADDRW-1:0]   addr_q;
    logic               err_q;

    logic [NUM_TARGETS-1:0] outstanding;
    logic [NUM_TARGETS-1:0] set_vec;
    logic [NUM_TARGETS-1:0] ack_vec;
    logic [3:0]             busy_vec;
    logic                   spur_evt;
    logic                   rsvd_evt;
    logic                   bus_ready;
    logic                   byte_acc;
    logic                   cmd_valid;
    logic                   handshake;
    logic [1:0]             hdr_dest;

    assign hdr_dest  = bus.bus_data_in[HDR_DEST_LSB +: 2];

    // Ready and valid depend only on registered state, never on cmd_ready.
    // The reserved slot of busy_vec keeps the index in range for any dest_q.
    assign busy_vec  = {1'b1, outstanding};
    assign bus_ready = (state_q != ST_ISSUE);
    assign byte_acc  = bus_ready && bus.bus_valid_in;
    assign cmd_valid = (state_q == ST_ISSUE) && !busy_vec[dest_q];
    assign handshake = cmd_valid && bus.cmd_ready;
    assign set_vec   = handshake ? (3'b001 << dest_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rsvd_evt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (byte_acc) begin
                    if (hdr_dest == DEST_RSVD) begin
                        rsvd_evt = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_acc && (cnt_q == CNT_LAST)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dest_q <= '0;
            opc_q  <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= rsvd_evt | spur_evt;
            if (byte_acc) begin
                if (state_q == ST_IDLE && hdr_dest != DEST_RSVD) begin
                    dest_q <= hdr_dest;
                    opc_q  <= bus.bus_data_in[HDR_OPC_LSB +: OPCODEW];
                    cnt_q  <= '0;
                end else if (state_q == ST_ADDR) begin
                    addr_q[8*cnt_q +: 8] <= bus.bus_data_in;
                    cnt_q                <= cnt_q + 1'b1;
                end
            end
        end
    end

    outstanding_tracker u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_vec     (set_vec),
        .done_in     (bus.done_in),
        .outstanding (outstanding),
        .ack_out     (ack_vec),
        .spur_evt    (spur_evt)
    );

    assign bus.bus_ready_out = bus_ready;
    assign bus.cmd_valid     = cmd_valid;
    assign bus.cmd_dest      = dest_q;
    assign bus.cmd_opcode    = opc_q;
    assign bus.cmd_addr      = addr_q;
    assign bus.ack_out       = ack_vec;
    assign bus.err_out       = err_q;

endmodule

// File: tb/tb_bus_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_bus_frame_decoder
// Self-checking bench: frames are pushed to an expected-command queue as they
// are driven and popped when the decoder completes a command handshake.
// ---------------------------------------------------------------------------
module tb_bus_frame_decoder;

    localparam int ADDRW   = 24;
    localparam int OPCODEW = 2;
    localparam int NBYTES  = ADDRW / 8;

    typedef struct packed {
        logic [1:0]         dest;
        logic [OPCODEW-1:0] opc;
        logic [ADDRW-1:0]   addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    bus_frame_decoder_if #(.ADDRW(ADDRW), .OPCODEW(OPCODEW)) bus ();

    bus_frame_decoder #(.ADDRW(ADDRW), .OPCODEW(OPCODEW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        bus.bus_data_in  = b;
        bus.bus_valid_in = 1'b1;
        while (bus.bus_ready_out !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (bus.bus_ready_out !== 1'b1)
            $display("FAIL send_byte_timeout: bus_ready_out=%b required 1", bus.bus_ready_out);
        else
            n_pass++;
        @(negedge clk);
        bus.bus_valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [ADDRW-1:0] addr,
                              input int unsigned gap);
        exp_t e;
        logic [7:0] b;
        if (hdr[7:6] != 2'd3) begin
            e.dest = hdr[7:6];
            e.opc  = hdr[4 +: OPCODEW];
            e.addr = addr;
            sb.push_back(e);
        end
        send_byte(hdr);
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (i != 0) repeat (gap) @(negedge clk);
            b = addr[8*i +: 8];
            send_byte(b);
        end
    endtask

    // Waits (bounded) for a handshake, compares against the scoreboard head,
    // and returns at the negedge after the handshake edge.
    task automatic expect_cmd(input string name, input int unsigned max_wait);
        int unsigned n = 0;
        exp_t e;
        while (!(bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!(bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1)) begin
            $display("FAIL %s_handshake: cmd_valid=%b after %0d cycles required 1", name, bus.cmd_valid, n);
            return;
        end
        n_pass++;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s_sb_empty: unexpected command dest=%0d addr=%h required none", name, bus.cmd_dest, bus.cmd_addr);
        end else begin
            n_pass++;
            e = sb.pop_front();
            n_total++;
            if (bus.cmd_dest !== e.dest) $display("FAIL %s_dest: got %0d required %0d", name, bus.cmd_dest, e.dest);
            else n_pass++;
            n_total++;
            if (bus.cmd_opcode !== e.opc) $display("FAIL %s_opcode: got %0d required %0d", name, bus.cmd_opcode, e.opc);
            else n_pass++;
            n_total++;
            if (bus.cmd_addr !== e.addr) $display("FAIL %s_addr: got %h required %h", name, bus.cmd_addr, e.addr);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    // Drives done_in for one edge; returns in the cycle after that edge.
    task automatic pulse_done(input logic [2:0] m);
        bus.done_in = m;
        @(negedge clk);
        bus.done_in = '0;
    endtask

    task automatic test_reset(input string tag);
        n_total++; if (bus.bus_ready_out !== 1'b1) $display("FAIL %s_ready: got %b required 1", tag, bus.bus_ready_out); else n_pass++;
        n_total++; if (bus.cmd_valid !== 1'b0) $display("FAIL %s_valid: got %b required 0", tag, bus.cmd_valid); else n_pass++;
        n_total++; if (bus.cmd_dest !== 2'd0) $display("FAIL %s_dest: got %0d required 0", tag, bus.cmd_dest); else n_pass++;
        n_total++; if (bus.cmd_opcode !== '0) $display("FAIL %s_opcode: got %0d required 0", tag, bus.cmd_opcode); else n_pass++;
        n_total++; if (bus.cmd_addr !== '0) $display("FAIL %s_addr: got %h required 0", tag, bus.cmd_addr); else n_pass++;
        n_total++; if (bus.ack_out !== 3'b000) $display("FAIL %s_ack: got %b required 000", tag, bus.ack_out); else n_pass++;
        n_total++; if (bus.err_out !== 1'b0) $display("FAIL %s_err: got %b required 0", tag, bus.err_out); else n_pass++;
    endtask

    task automatic test_basic();
        bus.cmd_ready = 1'b1;
        send_frame(8'h40, 24'h123456, 0);
        expect_cmd("basic", 0);
        n_total++; if (bus.cmd_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b required 0", bus.cmd_valid); else n_pass++;
        pulse_done(3'b010);
        n_total++; if (bus.ack_out !== 3'b010) $display("FAIL basic_ack: got %b required 010", bus.ack_out); else n_pass++;
        n_total++; if (bus.err_out !== 1'b0) $display("FAIL basic_err: got %b required 0", bus.err_out); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.ack_out !== 3'b000) $display("FAIL basic_ack_end: got %b required 000", bus.ack_out); else n_pass++;
    endtask

    task automatic test_hold();
        bus.cmd_ready = 1'b0;
        send_frame(8'h20, 24'hA5C3E1, 0);
        for (int i = 0; i < 3; i++) begin
            n_total++; if (bus.cmd_valid !== 1'b1) $display("FAIL hold_valid: got %b required 1", bus.cmd_valid); else n_pass++;
            n_total++; if (bus.bus_ready_out !== 1'b0) $display("FAIL hold_ready: got %b required 0", bus.bus_ready_out); else n_pass++;
            n_total++; if (bus.cmd_addr !== 24'hA5C3E1) $display("FAIL hold_addr: got %h required a5c3e1", bus.cmd_addr); else n_pass++;
            @(negedge clk);
        end
        bus.cmd_ready = 1'b1;
        expect_cmd("hold", 0);
        pulse_done(3'b001);
        n_total++; if (bus.ack_out !== 3'b001) $display("FAIL hold_ack: got %b required 001", bus.ack_out); else n_pass++;
    endtask

    task automatic test_blocked();
        bus.cmd_ready = 1'b1;
        send_frame(8'h90, 24'h0000FF, 0);
        expect_cmd("blk_first", 0);
        send_frame(8'h90, 24'hFEDCBA, 0);
        for (int i = 0; i < 4; i++) begin
            n_total++; if (bus.cmd_valid !== 1'b0) $display("FAIL blk_valid: got %b required 0", bus.cmd_valid); else n_pass++;
            n_total++; if (bus.bus_ready_out !== 1'b0) $display("FAIL blk_ready: got %b required 0", bus.bus_ready_out); else n_pass++;
            @(negedge clk);
        end
        pulse_done(3'b100);
        n_total++; if (bus.ack_out !== 3'b100) $display("FAIL blk_ack: got %b required 100", bus.ack_out); else n_pass++;
        n_total++; if (bus.cmd_valid !== 1'b1) $display("FAIL blk_release_valid: got %b required 1", bus.cmd_valid); else n_pass++;
        expect_cmd("blk_second", 0);
        pulse_done(3'b100);
        n_total++; if (bus.ack_out !== 3'b100) $display("FAIL blk_ack2: got %b required 100", bus.ack_out); else n_pass++;
    endtask

    task automatic test_rsvd();
        bus.cmd_ready = 1'b1;
        send_byte(8'hC0);
        n_total++; if (bus.err_out !== 1'b1) $display("FAIL rsvd_err: got %b required 1", bus.err_out); else n_pass++;
        n_total++; if (bus.bus_ready_out !== 1'b1) $display("FAIL rsvd_idle: got %b required 1", bus.bus_ready_out); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.err_out !== 1'b0) $display("FAIL rsvd_err_end: got %b required 0", bus.err_out); else n_pass++;
        n_total++; if (bus.cmd_valid !== 1'b0) $display("FAIL rsvd_valid: got %b required 0", bus.cmd_valid); else n_pass++;
        send_frame(8'h60, 24'h0F1E2D, 0);
        expect_cmd("rsvd_next", 0);
        pulse_done(3'b010);
        n_total++; if (bus.ack_out !== 3'b010) $display("FAIL rsvd_ack: got %b required 010", bus.ack_out); else n_pass++;
    endtask

    task automatic test_multi_done();
        bus.cmd_ready = 1'b1;
        send_frame(8'h10, 24'h00BEEF, 0);
        expect_cmd("multi", 0);
        pulse_done(3'b111);
        n_total++; if (bus.ack_out !== 3'b001) $display("FAIL multi_ack: got %b required 001", bus.ack_out); else n_pass++;
        n_total++; if (bus.err_out !== 1'b1) $display("FAIL multi_err: got %b required 1", bus.err_out); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.ack_out !== 3'b000) $display("FAIL multi_ack_end: got %b required 000", bus.ack_out); else n_pass++;
        n_total++; if (bus.err_out !== 1'b0) $display("FAIL multi_err_end: got %b required 0", bus.err_out); else n_pass++;
    endtask

    task automatic test_gaps();
        bus.cmd_ready = 1'b1;
        send_frame(8'h40, 24'h123456, 5);
        expect_cmd("gaps", 0);
        pulse_done(3'b010);
        n_total++; if (bus.ack_out !== 3'b010) $display("FAIL gaps_ack: got %b required 010", bus.ack_out); else n_pass++;
    endtask

    task automatic test_abort();
        bus.cmd_ready = 1'b1;
        send_frame(8'hA0, 24'h111111, 0);
        expect_cmd("abort_pre", 0);
        send_byte(8'h84);
        send_byte(8'h77);
        rst_n = 1'b0;
        #1;
        test_reset("abort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h80, 24'h5A0000, 0);
        expect_cmd("abort_next", 0);
        pulse_done(3'b100);
        n_total++; if (bus.ack_out !== 3'b100) $display("FAIL abort_ack: got %b required 100", bus.ack_out); else n_pass++;
        n_total++; if (bus.err_out !== 1'b0) $display("FAIL abort_err: got %b required 0", bus.err_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.cmd_ready = 1'b1;
        send_frame(8'h30, 24'hC0FFEE, 0);
        expect_cmd("b2b_mem", 0);
        send_frame(8'h50, 24'h000001, 0);
        expect_cmd("b2b_sha", 0);
        send_frame(8'hB0, 24'h800000, 0);
        expect_cmd("b2b_aes", 0);
        pulse_done(3'b111);
        n_total++; if (bus.ack_out !== 3'b111) $display("FAIL b2b_ack: got %b required 111", bus.ack_out); else n_pass++;
        n_total++; if (bus.err_out !== 1'b0) $display("FAIL b2b_err: got %b required 0", bus.err_out); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b1;
        bus.bus_data_in  = '0;
        bus.bus_valid_in = 1'b0;
        bus.cmd_ready    = 1'b0;
        bus.done_in      = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        test_reset("post_reset");

        test_basic();
        test_hold();
        test_blocked();
        test_rsvd();
        test_multi_done();
        test_gaps();
        test_abort();
        test_back_to_back();

        n_total++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d commands left, required 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
